// File: rtl/mux_rr_arbiter_2to1.sv
// Two-source round-robin arbiter feeding a registered 2:1 mux stage.
// Accepts one word per cycle from A or B over valid/ready handshakes. On a
// tie, the source that did not win last time is granted. The winning word
// goes into a one-entry output register with a valid/ready handshake, and
// its source tag is kept in `sel` to drive the downstream mux select.
module mux_rr_arbiter_2to1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             sel
);

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_data_q,  y_data_d;
  logic             sel_q,     sel_d;
  logic             last_q,    last_d;

  logic grant_a_c;
  logic grant_b_c;
  logic can_accept_c;
  logic accept_a_c;
  logic accept_b_c;

  // Grant from the valids and the priority bit only; no data-to-ready path
  always_comb begin
    grant_a_c    = a_valid & (~b_valid | (last_q == SRC_B));
    grant_b_c    = b_valid & (~a_valid | (last_q == SRC_A));
    can_accept_c = ~y_valid_q | y_ready;
  end

  // Readies are forced low while reset is asserted
  assign a_ready    = grant_a_c & can_accept_c & ~rst;
  assign b_ready    = grant_b_c & can_accept_c & ~rst;
  assign accept_a_c = a_valid & a_ready;
  assign accept_b_c = b_valid & b_ready;

  // Next state of the output register and priority bit
  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    sel_d     = sel_q;
    last_d    = last_q;
    if (accept_a_c) begin
      y_valid_d = 1'b1;
      y_data_d  = a_data;
      sel_d     = SRC_A;
      last_d    = SRC_A;
    end else if (accept_b_c) begin
      y_valid_d = 1'b1;
      y_data_d  = b_data;
      sel_d     = SRC_B;
      last_d    = SRC_B;
    end else if (y_ready) begin
      // Drain with nothing to refill: data and tag hold their last values
      y_valid_d = 1'b0;
    end
  end

  // State registers; last resets to B so A wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      sel_q     <= SRC_A;
      last_q    <= SRC_B;
    end else begin
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign sel     = sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter_2to1.sv
// Self-checking bench for mux_rr_arbiter_2to1: directed scenarios plus a
// randomized soak checked against a rule-level reference model and
// per-source scoreboards.
module tb_mux_rr_arbiter_2to1;

  logic       clk;
  logic       rst;
  logic       a_valid, b_valid, y_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, y_valid, sel;
  logic [7:0] y_data;

  int checks;
  int failures;

  // reference model state (rule level)
  logic       m_yv;
  logic [7:0] m_yd;
  logic       m_sel;
  logic       m_last;  // 0 = A accepted most recently, 1 = B
  logic       m_ar, m_br;

  // observations taken just before the active edge
  logic       obs_ar, obs_br, obs_yv, obs_sel;
  logic [7:0] obs_yd;

  mux_rr_arbiter_2to1 #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_ready (y_ready),
    .sel     (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Expected readies from the arbitration rules
  task automatic model_ready();
    logic can, ga, gb;
    can = !m_yv || y_ready;
    if (a_valid && b_valid) begin
      ga = (m_last == 1'b1);
      gb = (m_last == 1'b0);
    end else begin
      ga = a_valid;
      gb = b_valid;
    end
    m_ar = ga && can;
    m_br = gb && can;
  endtask

  // Drive one cycle starting at a falling edge; returns at the next falling edge
  task automatic drive_cycle(input logic av, input logic [7:0] ad,
                             input logic bv, input logic [7:0] bd,
                             input logic yr);
    a_valid = av; a_data = ad;
    b_valid = bv; b_data = bd;
    y_ready = yr;
    #1;
    model_ready();
    obs_ar  = a_ready;
    obs_br  = b_ready;
    obs_yv  = y_valid;
    obs_yd  = y_data;
    obs_sel = sel;
    @(posedge clk);
    if (m_ar && av) begin
      m_yv = 1'b1; m_yd = ad; m_sel = 1'b0; m_last = 1'b0;
    end else if (m_br && bv) begin
      m_yv = 1'b1; m_yd = bd; m_sel = 1'b1; m_last = 1'b1;
    end else if (yr) begin
      m_yv = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_yv = 1'b0; m_yd = 8'h00; m_sel = 1'b0; m_last = 1'b1;
  endtask

  task automatic apply_reset();
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({y_valid, sel, y_data} !== {1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_state: got %h expected %h", {y_valid, sel, y_data}, 10'h000);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
    checks++;
    if ({y_valid, sel, y_data} !== {1'b1, 1'b1, 8'h5A}) begin
      failures++;
      $display("FAIL reset_preload: got %h expected %h", {y_valid, sel, y_data}, {1'b1, 1'b1, 8'h5A});
    end
    // assert reset mid-cycle, away from any clock edge
    #2;
    a_valid = 1'b1; a_data = 8'h77; y_ready = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({y_valid, sel, y_data, a_ready, b_ready} !== 12'h000) begin
      failures++;
      $display("FAIL reset_async: got %h expected %h", {y_valid, sel, y_data, a_ready, b_ready}, 12'h000);
    end
    @(negedge clk);
    checks++;
    if ({y_valid, a_ready, b_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_held: got %b expected %b", {y_valid, a_ready, b_ready}, 3'b000);
    end
    rst = 1'b0;
    model_reset();
    b_valid = 1'b1; b_data = 8'h66;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_tie: got %b expected %b", {a_ready, b_ready}, 2'b10);
    end
  endtask

  task automatic test_single_source();
    logic [7:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, words[i], 1'b0, 8'h00, 1'b1);
      checks++;
      if ({obs_ar, obs_br} !== 2'b10) begin
        failures++;
        $display("FAIL single_ready[%0d]: got %b expected %b", i, {obs_ar, obs_br}, 2'b10);
      end
      checks++;
      if ({y_valid, sel, y_data} !== {1'b1, 1'b0, words[i]}) begin
        failures++;
        $display("FAIL single_out[%0d]: got %h expected %h", i, {y_valid, sel, y_data}, {1'b1, 1'b0, words[i]});
      end
    end
  endtask

  task automatic test_tie_alternation();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      logic       exp_sel;
      logic [7:0] exp_d;
      exp_sel = (i % 2 == 1);
      exp_d   = exp_sel ? 8'hBB : 8'hAA;
      drive_cycle(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
      checks++;
      if ({y_valid, sel, y_data} !== {1'b1, exp_sel, exp_d}) begin
        failures++;
        $display("FAIL tie_out[%0d]: got %h expected %h", i, {y_valid, sel, y_data}, {1'b1, exp_sel, exp_d});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] aw [3];
    logic [7:0] bw [3];
    logic       yr_pat  [7];
    logic [1:0] rdy_exp [7];
    logic [9:0] out_exp [7];
    int ai, bi;
    aw[0] = 8'hA0; aw[1] = 8'hA1; aw[2] = 8'hA2;
    bw[0] = 8'hB0; bw[1] = 8'hB1; bw[2] = 8'hB2;
    yr_pat[0] = 1; yr_pat[1] = 0; yr_pat[2] = 0; yr_pat[3] = 0;
    yr_pat[4] = 1; yr_pat[5] = 1; yr_pat[6] = 1;
    rdy_exp[0] = 2'b10; rdy_exp[1] = 2'b00; rdy_exp[2] = 2'b00; rdy_exp[3] = 2'b00;
    rdy_exp[4] = 2'b01; rdy_exp[5] = 2'b10; rdy_exp[6] = 2'b01;
    out_exp[0] = {2'b10, 8'hA0}; out_exp[1] = {2'b10, 8'hA0};
    out_exp[2] = {2'b10, 8'hA0}; out_exp[3] = {2'b10, 8'hA0};
    out_exp[4] = {2'b11, 8'hB0}; out_exp[5] = {2'b10, 8'hA1};
    out_exp[6] = {2'b11, 8'hB1};
    ai = 0; bi = 0;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1'b1, aw[ai], 1'b1, bw[bi], yr_pat[i]);
      if (obs_ar && ai < 2) ai++;
      if (obs_br && bi < 2) bi++;
      checks++;
      if ({obs_ar, obs_br} !== rdy_exp[i]) begin
        failures++;
        $display("FAIL bp_ready[%0d]: got %b expected %b", i, {obs_ar, obs_br}, rdy_exp[i]);
      end
      checks++;
      if ({y_valid, sel, y_data} !== out_exp[i]) begin
        failures++;
        $display("FAIL bp_out[%0d]: got %h expected %h", i, {y_valid, sel, y_data}, out_exp[i]);
      end
    end
  endtask

  task automatic test_priority_memory();
    logic [7:0] aw [3];
    logic [9:0] out_exp [4];
    int ai;
    aw[0] = 8'hC0; aw[1] = 8'hC1; aw[2] = 8'hC2;
    out_exp[0] = {2'b10, 8'hC0}; out_exp[1] = {2'b10, 8'hC1};
    out_exp[2] = {2'b11, 8'hD0}; out_exp[3] = {2'b10, 8'hC2};
    ai = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, aw[ai], (i >= 2), 8'hD0, 1'b1);
      if (obs_ar && ai < 2) ai++;
      checks++;
      if ({y_valid, sel, y_data} !== out_exp[i]) begin
        failures++;
        $display("FAIL prio_out[%0d]: got %h expected %h", i, {y_valid, sel, y_data}, out_exp[i]);
      end
    end
  endtask

  task automatic test_random_soak();
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic       a_hold, b_hold, yr;
    logic [7:0] a_word, b_word, exp_d;
    int a_wait, b_wait;
    a_hold = 0; b_hold = 0; a_word = 0; b_word = 0;
    a_wait = 0; b_wait = 0;
    apply_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!a_hold && $urandom_range(0, 99) < 70) begin a_hold = 1; a_word = 8'($urandom); end
      if (!b_hold && $urandom_range(0, 99) < 70) begin b_hold = 1; b_word = 8'($urandom); end
      yr = ($urandom_range(0, 3) != 0);
      drive_cycle(a_hold, a_word, b_hold, b_word, yr);

      checks++;
      if ({obs_ar, obs_br} !== {m_ar, m_br}) begin
        failures++;
        $display("FAIL soak_ready @%0d: got %b expected %b", cyc, {obs_ar, obs_br}, {m_ar, m_br});
      end
      checks++;
      if ((obs_ar && !a_hold) || (obs_br && !b_hold) || (obs_ar && obs_br)) begin
        failures++;
        $display("FAIL soak_bad_grant @%0d: got %b expected legal for valids %b", cyc, {obs_ar, obs_br}, {a_hold, b_hold});
      end
      // delivery before acceptance: a word accepted this cycle cannot leave yet
      if (obs_yv && yr) begin
        checks++;
        if ((obs_sel ? qb.size() : qa.size()) == 0) begin
          failures++;
          $display("FAIL soak_spurious @%0d: got word %h sel %b expected none", cyc, obs_yd, obs_sel);
        end else begin
          exp_d = obs_sel ? qb.pop_front() : qa.pop_front();
          if (obs_yd !== exp_d) begin
            failures++;
            $display("FAIL soak_data @%0d: got %h expected %h (sel %b)", cyc, obs_yd, exp_d, obs_sel);
          end
        end
      end
      if (a_hold && obs_ar) begin qa.push_back(a_word); a_hold = 0; end
      if (b_hold && obs_br) begin qb.push_back(b_word); b_hold = 0; end

      checks++;
      if ({y_valid, sel, y_data} !== {m_yv, m_sel, m_yd}) begin
        failures++;
        $display("FAIL soak_out @%0d: got %h expected %h", cyc, {y_valid, sel, y_data}, {m_yv, m_sel, m_yd});
      end
      // fairness: a waiting source sees at most one grant to the other
      if (obs_ar) a_wait = 0; else if (a_hold && obs_br) a_wait++;
      if (obs_br) b_wait = 0; else if (b_hold && obs_ar) b_wait++;
      checks++;
      if (a_wait > 1 || b_wait > 1) begin
        failures++;
        $display("FAIL soak_fair @%0d: got waits %0d/%0d expected <=1", cyc, a_wait, b_wait);
      end
    end
    checks++;
    if (qa.size() + qb.size() != (m_yv ? 1 : 0)) begin
      failures++;
      $display("FAIL soak_outstanding: got %0d expected %0d", qa.size() + qb.size(), m_yv ? 1 : 0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    model_reset();
    test_reset();
    test_single_source();
    test_tie_alternation();
    test_backpressure();
    test_priority_memory();
    test_random_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
